mux4_serializer: RTL

Upstream sequencer for the 4:1 bit multiplexer. It accepts a 4-bit word through a valid/ready handshake and holds it on the mux data bus (i_out). It then steps the mux select (sel) through all four slots, one slot per HOLD_CYCLES clocks, so the downstream mux emits the word as a serial bit stream. It also provides framing flags (slot_valid, last_slot, done) to the serial consumer.

---
 rtl/mux4_serializer.sv | 68 ++++++
 1 files changed

// File: rtl/mux4_serializer.sv
// Sequencer for a 4:1 bit mux: latches a 4-bit word, then walks the select
// through all four slots (HOLD_CYCLES clocks each) with framing flags.
module mux4_serializer #(
    parameter int HOLD_CYCLES = 1,
    parameter bit LSB_FIRST   = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] i_out,
    output logic [1:0] sel,
    output logic       slot_valid,
    output logic       last_slot,
    output logic       done
);

    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 16) begin : g_bad_hold
        $error("mux4_serializer: HOLD_CYCLES must be in 1..16");
    end

    localparam logic [1:0] FIRST = LSB_FIRST ? 2'd0 : 2'd3;
    localparam logic [1:0] LAST  = LSB_FIRST ? 2'd3 : 2'd0;
    localparam logic [3:0] HMAX  = 4'(HOLD_CYCLES - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       accept;

    // Flags are combinational so a new word can load on the done edge with no bubble.
    assign last_slot = (state == SHIFT) && (sel == LAST);
    assign done      = last_slot && (cnt == HMAX);
    assign in_ready  = (state == IDLE) || done;
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            i_out      <= 4'd0;
            sel        <= FIRST;
            slot_valid <= 1'b0;
        end else if (accept) begin
            state      <= SHIFT;
            cnt        <= 4'd0;
            i_out      <= in_data;
            sel        <= FIRST;
            slot_valid <= 1'b1;
        end else if (state == SHIFT) begin
            if (cnt == HMAX) begin
                cnt <= 4'd0;
                // sel parks on the last index in IDLE; only a load returns it to FIRST.
                if (sel == LAST) begin
                    state      <= IDLE;
                    slot_valid <= 1'b0;
                end else begin
                    sel <= LSB_FIRST ? sel + 2'd1 : sel - 2'd1;
                end
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end

endmodule
